muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have no parameters; the datapath width SHALL be fixed at 32 bits.
REQ-002 clk  input  1  Single clock; all state SHALL change on the rising edge only.
REQ-003 reset  input  1  Asynchronous, active-low reset; reset asserted when reset=0.
REQ-004 start  input  1  Operation request, sampled on the rising edge.
REQ-005 op  input  2  Operation select: 00 mult, 01 multu, 10 div, 11 divu.
REQ-006 a  input  32  Multiplicand or dividend, sampled with start.
REQ-007 b  input  32  Multiplier or divisor, sampled with start.
REQ-008 hi_we  input  1  Write enable for hi (mthi).
REQ-009 lo_we  input  1  Write enable for lo (mtlo).
REQ-010 wd  input  32  Write data for hi_we/lo_we.
REQ-011 busy  output  1  High while an operation is in progress.
REQ-012 done  output  1  One-cycle pulse when hi/lo hold a new result.
REQ-013 hi  output  32  HI register; product[63:32] or remainder.
REQ-014 lo  output  32  LO register; product[31:0] or quotient.

Function
REQ-015 The block SHALL implement three states: IDLE, CALC and DONE.
REQ-016 busy SHALL equal (state==CALC) and done SHALL equal (state==DONE); both SHALL be registered-state decodes.
REQ-017 In IDLE, start=1 at edge E0 SHALL latch a, b and op, clear a 5-bit iteration counter, and move the block to CALC.
REQ-018 In CALC, each edge SHALL perform one radix-2 iteration (shift-add for multiply, restoring shift-subtract for divide) and increment the counter.
REQ-019 The 32nd iteration SHALL occur at edge E32; at that edge the block SHALL apply sign fix-up, write hi/lo, and move to DONE.
REQ-020 The block SHALL return from DONE to IDLE on the next edge (E33) unconditionally.
REQ-021 Latency: done SHALL be high for exactly the cycle between E32 and E33, and busy SHALL be high from E0 until E32.
REQ-022 Signed ops SHALL operate on operand magnitudes; the product SHALL be negated when the operand signs differ.
REQ-023 For signed divide, the quotient sign SHALL be sign(a) XOR sign(b) and the remainder sign SHALL follow the dividend.
REQ-024 For mult/multu, the full 64-bit result SHALL be exact.
REQ-025 Divide by zero (b=0, div or divu) SHALL produce lo=32'hFFFFFFFF and hi=a; this path SHALL take the same 33-cycle latency.
REQ-026 div of 32'h80000000 by 32'hFFFFFFFF SHALL produce lo=32'h80000000 and hi=0.
REQ-027 start while in CALC or DONE SHALL be ignored without side effects.
REQ-028 hi_we/lo_we in IDLE without start SHALL write wd to hi/lo at the edge; both may be written in the same cycle.
REQ-029 hi_we/lo_we in CALC or DONE SHALL be ignored.
REQ-030 When start and hi_we/lo_we are asserted together in IDLE, start SHALL take precedence and the writes SHALL be dropped.
REQ-031 hi/lo SHALL hold their values between operations; intermediate results SHALL never be visible on hi/lo.

Reset
REQ-032 reset=0 SHALL asynchronously force state=IDLE, hi=0, lo=0, busy=0, done=0, the counter to 0, and the operand registers to 0.
REQ-033 Reset during CALC SHALL abort the operation with no done pulse; a start after release SHALL begin a fresh operation.
REQ-034 The first start SHALL be accepted on the first rising edge after reset release.

Verification
REQ-035 mult a=7, b=32'hFFFFFFFD -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB, with done exactly 33 edges after the start edge and busy high for 32 cycles.
REQ-036 multu a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001; mult of the same operands -> hi=0, lo=1.
REQ-037 div a=-7, b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; divu a=100, b=7 -> lo=14, hi=2; div 32'h80000000/-1 -> lo=32'h80000000, hi=0.
REQ-038 divu a=5, b=0 -> lo=32'hFFFFFFFF, hi=5 after 33 cycles.
REQ-039 Start multu 3*4, pulse reset=0 at cycle 10 -> busy=0, hi=lo=0, and no done pulse; then start multu 3*4 -> lo=12.
REQ-040 Start while busy with different operands -> ignored and the first result is unchanged; hi_we with wd=32'h1234 in IDLE -> hi=32'h1234; hi_we together with start -> hi reflects only the operation result.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// One radix-2 step per cycle: 32 steps, then a single DONE cycle.
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wd,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [4:0]  count;
    logic [1:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [63:0] acc;

    logic        in_signed;
    logic [31:0] mag_a_in;

    logic        op_signed;
    logic        is_div;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_b;

    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic [63:0] div_next;
    logic [63:0] step_next;

    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    // op[1] selects divide, op[0] selects unsigned
    assign in_signed = ~op[0];
    assign mag_a_in  = (in_signed && a[31]) ? (32'd0 - a) : a;

    assign op_signed = ~op_q[0];
    assign is_div    = op_q[1];
    assign a_neg     = op_signed & a_q[31];
    assign b_neg     = op_signed & b_q[31];
    assign mag_b     = b_neg ? (32'd0 - b_q) : b_q;

    // Multiply: acc = {partial product, remaining multiplier bits}
    assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_b} : 33'd0);
    assign mul_next = {mul_sum, acc[31:1]};

    // Restoring divide: acc = {partial remainder, dividend/quotient bits}
    assign div_shift = {acc[63:32], acc[31]};
    assign div_diff  = div_shift - {1'b0, mag_b};
    assign div_next  = div_diff[32] ? {div_shift[31:0], acc[30:0], 1'b0}
                                    : {div_diff[31:0],  acc[30:0], 1'b1};

    assign step_next = is_div ? div_next : mul_next;

    // Sign fix-up applied to the result of the final step only
    assign prod_fix = (a_neg ^ b_neg) ? (64'd0 - step_next) : step_next;
    assign quo_fix  = (a_neg ^ b_neg) ? (32'd0 - step_next[31:0]) : step_next[31:0];
    assign rem_fix  = a_neg ? (32'd0 - step_next[63:32]) : step_next[63:32];

    always_comb begin
        res_hi = prod_fix[63:32];
        res_lo = prod_fix[31:0];
        if (is_div) begin
            if (b_q == 32'd0) begin
                res_hi = a_q;
                res_lo = 32'hFFFF_FFFF;
            end else begin
                res_hi = rem_fix;
                res_lo = quo_fix;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            count <= 5'd0;
            op_q  <= 2'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            acc   <= 64'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        a_q   <= a;
                        b_q   <= b;
                        count <= 5'd0;
                        acc   <= {32'd0, mag_a_in};
                        state <= CALC;
                        busy  <= 1'b1;
                    end else begin
                        if (hi_we) hi <= wd;
                        if (lo_we) lo <= wd;
                    end
                end
                CALC: begin
                    acc   <= step_next;
                    count <= count + 5'd1;
                    if (count == 5'd31) begin
                        hi    <= res_hi;
                        lo    <= res_lo;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected HI/LO,
// a negedge monitor pops and compares on every done pulse.
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wd;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          issue;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    muldiv_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wd    (wd),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (reset && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                $display("[TB] %s hi=%h lo=%h latency=%0d", e.name, hi, lo, cyc - e.issue);
                check({e.name, " hi"}, hi, e.hi);
                check({e.name, " lo"}, lo, e.lo);
                check({e.name, " latency"}, cyc - e.issue, 32'd33);
            end
        end
    end

    // mode 0: plain op; 1: hi_we/lo_we alongside start; 2: start+writes injected while busy
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                          input int mode);
        int  bc;
        bit  ok;
        exp_t e;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (mode == 1) begin
            hi_we = 1'b1;
            lo_we = 1'b1;
            wd    = 32'hDEAD_BEEF;
        end
        e.hi = eh;
        e.lo = el;
        e.issue = cyc;
        e.name = name;
        sb.push_back(e);
        @(negedge clk); #1;
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        bc = 0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (busy) bc++;
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
            if (mode == 2 && i == 5) begin
                start = 1'b1;
                op    = 2'b11;
                a     = 32'd9;
                b     = 32'd2;
                hi_we = 1'b1;
                lo_we = 1'b1;
                wd    = 32'h5555_5555;
            end else begin
                start = 1'b0;
                hi_we = 1'b0;
                lo_we = 1'b0;
            end
            @(negedge clk); #1;
        end
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        if (!ok) begin
            check({name, " timeout"}, 32'd1, 32'd0);
            sb.delete();
        end
        check({name, " busy_cycles"}, bc, 32'd32);
        @(negedge clk); #1;
        check({name, " idle_busy"}, {31'd0, busy}, 32'd0);
        check({name, " idle_done"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = 32'd0;
        b     = 32'd0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wd    = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);

        // Start accepted on the first edge after release
        reset = 1'b1;
        run_op("mult_7_x_m3",      2'b00, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
        run_op("multu_max_sq",     2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
        run_op("mult_m1_sq",       2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 0);
        run_op("mult_2p30_x_4",    2'b00, 32'h4000_0000, 32'd4,        32'h0000_0001, 32'h0000_0000, 0);
        run_op("div_m7_by_2",      2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_op("div_7_by_m2",      2'b10, 32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0);
        run_op("divu_100_by_7",    2'b11, 32'd100,      32'd7,        32'd2,         32'd14,        0);
        run_op("div_min_by_m1",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0);
        run_op("divu_5_by_0",      2'b11, 32'd5,        32'd0,        32'd5,         32'hFFFF_FFFF, 0);
        run_op("div_m20_by_0",     2'b10, 32'hFFFF_FFEC, 32'd0,        32'hFFFF_FFEC, 32'hFFFF_FFFF, 0);

        // Start and register writes while busy are ignored
        run_op("multu_busy_inject", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 2);
        repeat (3) @(negedge clk);
        #1;
        check("hold_hi", hi, 32'd0);
        check("hold_lo", lo, 32'd12);

        hi_we = 1'b1;
        wd    = 32'h0000_1234;
        @(negedge clk); #1;
        hi_we = 1'b0;
        check("mthi_hi", hi, 32'h0000_1234);
        check("mthi_lo_kept", lo, 32'd12);

        hi_we = 1'b1;
        lo_we = 1'b1;
        wd    = 32'h0000_ABCD;
        @(negedge clk); #1;
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("mthilo_hi", hi, 32'h0000_ABCD);
        check("mthilo_lo", lo, 32'h0000_ABCD);

        // Writes issued with start are dropped
        run_op("multu_with_we", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1);

        hi_we = 1'b1;
        wd    = 32'h0000_0077;
        @(negedge clk); #1;
        hi_we = 1'b0;

        // Abort in CALC with reset; no done pulse may follow
        start = 1'b1;
        op    = 2'b01;
        a     = 32'd3;
        b     = 32'd4;
        @(negedge clk); #1;
        start = 1'b0;
        repeat (9) @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b1;
        run_op("multu_after_reset", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 0);

        repeat (40) @(negedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
